fetch2: RTL and testbench
=========================

# fetch2

Second instruction-fetch stage of the rv32i pipeline, directly downstream of fetch1 and upstream of decode. It records the PC of every instruction-memory request fetch1 issues and pairs each in-order `imem_resp` with its PC. It buffers completed instructions in a DEPTH-entry queue so decode stalls never lose a response. On a taken branch it flushes all buffered and in-flight instructions, then silently drops responses that were already outstanding.

## Interface
- `DEPTH`, 2: number of queue entries; must be a power of two and at least 2; also bounds outstanding requests.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_fire`  in  1  fetch1 issued a request to imem this cycle.
- `req_pc`  in  32  address of that request (fetch1 `if_id_reg_next.pc`).
- `imem_rdata`  in  32  instruction word; valid when `imem_resp`.
- `imem_resp`  in  1  one in-order response this cycle.
- `flush`  in  1  taken branch/redirect (fetch1 `br_en`).
- `stall`  in  1  decode cannot accept this cycle.
- `full`  out  1  fetch1 must not assert `req_fire` while high.
- `id_valid`  out  1  head entry holds a completed instruction.
- `id_pc`  out  32  PC of head entry.
- `id_inst`  out  32  instruction of head entry.

## Operation
- Queue entry: {pc, inst, filled}. It has head and tail pointers, a fill pointer (oldest unfilled entry) and `count`. All pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `drop_cnt` ($clog2(DEPTH)+1 bits) counts responses still owed to flushed requests.
- `full` = (`count` + `drop_cnt`) == DEPTH. Combinational from registers only.
- Allocate: on `req_fire`, write {`req_pc`, x, 0} at tail; tail++ and count++.
- Response, applied in this order:
  - If `drop_cnt` > 0: decrement `drop_cnt` and discard the data.
  - Else if an unfilled entry exists: write `imem_rdata` at the fill pointer, set filled, and advance the fill pointer.
  - Else: ignore the response (protocol error).
- Pop: when `id_valid` && !`stall`, head++ and count--.
- `id_valid` = count>0 && head.filled. `id_pc`/`id_inst` come from the head entry and are 0 when `id_valid` is low.
- Flush:
  - Responses first: `imem_resp` in the same cycle is consumed against pre-flush state.
  - Then clear: `drop_cnt_next` = `drop_cnt` + unfilled_count − `imem_resp`. All entries are invalidated and count, head, tail and fill pointer go to 0.
  - A simultaneous pop is irrelevant because the queue is cleared.
- `req_fire` in the same cycle as `flush` is the redirect target. It is allocated after the clear, so count=1 next cycle.
- Simultaneous `req_fire` and pop: count is unchanged. Simultaneous fill and pop of the same head entry cannot occur without bypass (see Configuration).
- `req_fire` while `full` is a protocol error; the request is ignored and state is unchanged.

## Timing
- Reset (`rst`=0, asynchronous): count, pointers and `drop_cnt` = 0; `id_valid`=0, `id_pc`=0, `id_inst`=0, `full`=0.
- Responses arriving after reset with nothing outstanding are ignored. Imem must be quiesced across reset.
- Baseline latency: `imem_resp` in cycle N makes `id_valid` high in cycle N+1, if that entry is at head.
- Outputs hold stable while `stall` is high.
- Throughput: one instruction per cycle sustained with DEPTH≥2, given back-to-back responses.
- `full` deasserts in the cycle after a pop or a dropped response frees a slot.

## Configuration
- `FETCH2_BYPASS_EN` defined:
  - When the head entry is unfilled and `imem_resp` targets it with `drop_cnt`==0 and no `flush`, `id_valid`=1 the same cycle, with `id_inst`=`imem_rdata`.
  - If also !`stall`, the entry is filled and popped in one cycle.
  - Response-to-decode latency is 0.
- Not defined: outputs depend only on registers; latency is 1 cycle as above.

## Test plan
- Reset, then `req_fire` with `req_pc`=0x60000000. Next cycle `imem_resp` with rdata=0x00000013 -> `id_valid`=1, `id_pc`=0x60000000, `id_inst`=0x00000013 one cycle later (same cycle with `FETCH2_BYPASS_EN`).
- Issue 0x60000000 and 0x60000004 with `stall` held high; respond to both -> `full`=1, head holds 0x60000000. Release `stall` -> 0x60000000 then 0x60000004 on consecutive cycles, then `full`=0.
- Two requests outstanding, no responses, then `flush` with `req_fire`(0x60000100) -> `drop_cnt`=2 and count=1. Next three responses 0xAAAAAAAA, 0xBBBBBBBB, 0x00100093 -> only `id_pc`=0x60000100 with `id_inst`=0x00100093 appears.
- `flush` in the same cycle as `imem_resp` for the sole outstanding request -> response discarded, `drop_cnt`=0, `id_valid` stays 0.
- Fill the queue, then assert `rst` low mid-stream -> all outputs 0 immediately. After release, a stray `imem_resp` is ignored (`id_valid`=0).
- Wrap-around: stream 8 sequential PCs from 0x60000000 with `stall` toggling every other cycle -> all 8 delivered in order, none duplicated or lost.

Source files
------------

// File: rtl/fetch2_if.sv
// Fetch2 handshake bundle: fetch1 requests, imem responses, decode side.
// The master drives requests, responses, flush and stall; the slave (fetch2) drives the queue outputs.
interface fetch2_if;
    logic        req_fire;
    logic [31:0] req_pc;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        flush;
    logic        stall;
    logic        full;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    modport master (
        output req_fire, req_pc, imem_rdata, imem_resp, flush, stall,
        input  full, id_valid, id_pc, id_inst
    );

    modport slave (
        input  req_fire, req_pc, imem_rdata, imem_resp, flush, stall,
        output full, id_valid, id_pc, id_inst
    );
endinterface

// File: rtl/fetch2.sv
// Second fetch stage: pairs in-order imem responses with request PCs in a DEPTH-entry queue.
// Optional FETCH2_BYPASS_EN forwards a response straight to decode when it fills the head entry.
module fetch2 #(
    parameter int DEPTH = 2
) (
    input logic     clk,
    input logic     rst,
    fetch2_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [PW-1:0]    head, tail, fill_ptr;
    logic [CW-1:0]    count, pend, drop_cnt;

    logic [CW:0]   occupancy;
    logic          full_int;
    logic          alloc, resp_drop, resp_fill;
    logic          head_ready, bypass, valid, pop;
    logic [PW-1:0] alloc_idx;

    assign occupancy = {1'b0, count} + {1'b0, drop_cnt};
    assign full_int  = (occupancy == (CW+1)'(DEPTH));

    assign alloc     = bus.req_fire && !full_int;
    assign resp_drop = bus.imem_resp && (drop_cnt != '0);
    assign resp_fill = bus.imem_resp && (drop_cnt == '0) && (pend != '0);

    assign head_ready = (count != '0) && filled[head];
`ifdef FETCH2_BYPASS_EN
    // An unfilled head is always the fill target, so the response belongs to it.
    assign bypass = resp_fill && !bus.flush && (count != '0) && !filled[head];
`else
    assign bypass = 1'b0;
`endif
    assign valid = head_ready || bypass;
    assign pop   = valid && !bus.stall;

    // After a flush the redirect target lands in slot 0 of the cleared queue.
    assign alloc_idx = bus.flush ? '0 : tail;

    assign bus.full     = full_int;
    assign bus.id_valid = valid;
    assign bus.id_pc    = valid ? pc_q[head] : 32'h0;
    assign bus.id_inst  = head_ready ? inst_q[head] : (bypass ? bus.imem_rdata : 32'h0);

    always_ff @(posedge clk) begin
        if (alloc) begin
            pc_q[alloc_idx] <= bus.req_pc;
        end
        if (resp_fill) begin
            inst_q[fill_ptr] <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filled   <= '0;
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= '0;
        end else if (bus.flush) begin
            // Every unfilled entry still has a response in flight that must be discarded.
            drop_cnt <= drop_cnt + pend - CW'(resp_drop || resp_fill);
            filled   <= '0;
            head     <= '0;
            fill_ptr <= '0;
            tail     <= alloc ? PW'(1) : '0;
            count    <= alloc ? CW'(1) : '0;
            pend     <= alloc ? CW'(1) : '0;
        end else begin
            if (resp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (resp_fill) begin
                filled[fill_ptr] <= 1'b1;
            end
            if (alloc) begin
                filled[tail] <= 1'b0;
            end
            fill_ptr <= fill_ptr + PW'(resp_fill);
            tail     <= tail + PW'(alloc);
            head     <= head + PW'(pop);
            count    <= count + CW'(alloc) - CW'(pop);
            pend     <= pend + CW'(alloc) - CW'(resp_fill);
        end
    end
endmodule

// File: tb/tb_fetch2.sv
// Randomized and directed bench for fetch2 against a queue-based reference model.
// Build with FETCH2_BYPASS_EN defined to check the zero-latency variant.
module tb_fetch2;
    localparam int DEPTH = 4;
    localparam logic [31:0] BASE = 32'h6000_0000;

    logic clk;
    logic rst;
    fetch2_if bus();

    fetch2 #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: PCs awaiting a response, completed instructions, owed drops.
    logic [31:0] m_pend[$];
    logic [31:0] m_done_pc[$];
    logic [31:0] m_done_inst[$];
    int          m_drop = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic bp_hit();
`ifdef FETCH2_BYPASS_EN
        return m_done_pc.size() == 0 && m_pend.size() > 0 && bus.imem_resp && m_drop == 0 && !bus.flush;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic e_valid();
        return m_done_pc.size() > 0 || bp_hit();
    endfunction

    function automatic logic [31:0] e_pc();
        if (m_done_pc.size() > 0) return m_done_pc[0];
        if (bp_hit()) return m_pend[0];
        return 32'h0;
    endfunction

    function automatic logic [31:0] e_inst();
        if (m_done_pc.size() > 0) return m_done_inst[0];
        if (bp_hit()) return bus.imem_rdata;
        return 32'h0;
    endfunction

    function automatic logic e_full();
        return (m_pend.size() + m_done_pc.size() + m_drop) == DEPTH;
    endfunction

    function automatic logic [65:0] obs_vec();
        return {bus.id_valid, bus.id_pc, bus.id_inst, bus.full};
    endfunction

    function automatic logic [65:0] exp_vec();
        return {e_valid(), e_pc(), e_inst(), e_full()};
    endfunction

    task automatic model_reset();
        m_pend.delete();
        m_done_pc.delete();
        m_done_inst.delete();
        m_drop = 0;
    endtask

    task automatic model_step();
        logic pop;
        logic full_pre;
        pop      = e_valid() && !bus.stall;
        full_pre = e_full();
        if (bus.imem_resp) begin
            if (m_drop > 0) begin
                m_drop--;
            end else if (m_pend.size() > 0) begin
                m_done_pc.push_back(m_pend.pop_front());
                m_done_inst.push_back(bus.imem_rdata);
            end
        end
        if (bus.flush) begin
            m_drop += m_pend.size();
            m_pend.delete();
            m_done_pc.delete();
            m_done_inst.delete();
        end else if (pop) begin
            void'(m_done_pc.pop_front());
            void'(m_done_inst.pop_front());
        end
        if (bus.req_fire && !full_pre) m_pend.push_back(bus.req_pc);
    endtask

    task automatic drive(input logic rf, input logic [31:0] pc, input logic rs,
                         input logic [31:0] rd, input logic fl, input logic st);
        bus.req_fire   = rf;
        bus.req_pc     = pc;
        bus.imem_resp  = rs;
        bus.imem_rdata = rd;
        bus.flush      = fl;
        bus.stall      = st;
        @(negedge clk);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.id_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.id_valid); else n_pass++;
        n_checks++;
        if (bus.id_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", bus.id_pc); else n_pass++;
        n_checks++;
        if (bus.id_inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", bus.id_inst); else n_pass++;
        n_checks++;
        if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic seen;
        seen = 1'b0;
        drive(1, BASE, 0, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL basic_req: got %h want %h", obs_vec(), exp_vec()); else n_pass++;
        tick();
        drive(0, 0, 1, 32'h0000_0013, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL basic_resp: got %h want %h", obs_vec(), exp_vec()); else n_pass++;
        if (bus.id_valid && bus.id_pc == BASE && bus.id_inst == 32'h13) seen = 1'b1;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL basic_out: got %h want %h", obs_vec(), exp_vec()); else n_pass++;
        if (bus.id_valid && bus.id_pc == BASE && bus.id_inst == 32'h13) seen = 1'b1;
        n_checks++;
        if (seen !== 1'b1) $display("FAIL basic_delivered: got %b want 1", seen); else n_pass++;
        tick();
    endtask

    task automatic test_stall_full();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, BASE + 32'(4*i), i > 0, 32'h100 + 32'(i-1), 0, 1);
            tick();
        end
        drive(0, 0, 1, 32'h100 + 32'(DEPTH-1), 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_checks++;
        if (bus.full !== 1'b1) $display("FAIL stall_full: got %b want 1", bus.full); else n_pass++;
        n_checks++;
        if (bus.id_pc !== BASE) $display("FAIL stall_head: got %h want %h", bus.id_pc, BASE); else n_pass++;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            n_checks++;
            if ({bus.id_valid, bus.id_pc, bus.id_inst} !== {1'b1, BASE + 32'(4*i), 32'h100 + 32'(i)})
                $display("FAIL drain_%0d: got v=%b pc=%h inst=%h want pc=%h", i,
                         bus.id_valid, bus.id_pc, bus.id_inst, BASE + 32'(4*i));
            else n_pass++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({bus.full, bus.id_valid} !== 2'b00) $display("FAIL drain_empty: got full=%b v=%b want 0 0", bus.full, bus.id_valid); else n_pass++;
        tick();
    endtask

    task automatic test_flush_drop();
        logic [31:0] got_pc[$];
        logic [31:0] got_inst[$];
        logic [31:0] data[3];
        data[0] = 32'hAAAA_AAAA; data[1] = 32'hBBBB_BBBB; data[2] = 32'h0010_0093;
        drive(1, BASE + 32'h10, 0, 0, 0, 0); tick();
        drive(1, BASE + 32'h14, 0, 0, 0, 0); tick();
        drive(1, BASE + 32'h100, 0, 0, 1, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL flush_cycle: got %h want %h", obs_vec(), exp_vec()); else n_pass++;
        tick();
        n_checks++;
        if (dut.drop_cnt !== 3'd2) $display("FAIL flush_drop_cnt: got %0d want 2", dut.drop_cnt); else n_pass++;
        n_checks++;
        if (dut.count !== 3'd1) $display("FAIL flush_count: got %0d want 1", dut.count); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, k < 3, k < 3 ? data[k] : 32'h0, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL flush_resp_%0d: got %h want %h", k, obs_vec(), exp_vec()); else n_pass++;
            if (bus.id_valid) begin
                got_pc.push_back(bus.id_pc);
                got_inst.push_back(bus.id_inst);
            end
            tick();
        end
        n_checks++;
        if (got_pc.size() != 1 || got_pc[0] !== BASE + 32'h100 || got_inst[0] !== 32'h0010_0093)
            $display("FAIL flush_only_target: got %0d deliveries first pc=%h want 1 pc=%h inst=00100093",
                     got_pc.size(), got_pc.size() > 0 ? got_pc[0] : 32'h0, BASE + 32'h100);
        else n_pass++;
    endtask

    task automatic test_flush_resp();
        drive(1, BASE + 32'h200, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 32'hDEAD_BEEF, 1, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL flush_resp_cycle: got %h want %h", obs_vec(), exp_vec()); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (dut.drop_cnt !== 3'd0) $display("FAIL flush_resp_drop: got %0d want 0", dut.drop_cnt); else n_pass++;
        n_checks++;
        if (bus.id_valid !== 1'b0) $display("FAIL flush_resp_valid: got %b want 0", bus.id_valid); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, BASE + 32'(4*i), i > 0, 32'h300 + 32'(i), 0, 1);
            tick();
        end
        bus.req_fire = 1'b0; bus.imem_resp = 1'b0; bus.flush = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs_vec() !== 66'h0) $display("FAIL reset_mid_outputs: got %h want 0", obs_vec()); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        drive(0, 0, 1, 32'h1234_5678, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL stray_cycle: got %h want %h", obs_vec(), exp_vec()); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.id_valid !== 1'b0) $display("FAIL stray_ignored: got %b want 0", bus.id_valid); else n_pass++;
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] got_pc[$];
        logic [31:0] got_inst[$];
        int issued;
        int errs;
        issued = 0;
        errs   = 0;
        for (int cyc = 0; cyc < 100 && got_pc.size() < 8; cyc++) begin
            logic rf;
            logic rs;
            logic [31:0] rd;
            rf = issued < 8 && !e_full();
            rs = m_pend.size() > 0;
            rd = rs ? (m_pend[0] ^ 32'h0F0F_0000) : 32'h0;
            drive(rf, BASE + 32'(4*issued), rs, rd, 0, cyc[0]);
            if (rf) issued++;
            if (obs_vec() !== exp_vec()) errs++;
            if (bus.id_valid && !bus.stall) begin
                got_pc.push_back(bus.id_pc);
                got_inst.push_back(bus.id_inst);
            end
            tick();
        end
        n_checks++;
        if (errs != 0) $display("FAIL wrap_cycles: got %0d cycle mismatches want 0", errs); else n_pass++;
        n_checks++;
        if (got_pc.size() != 8) $display("FAIL wrap_count: got %0d want 8", got_pc.size()); else n_pass++;
        for (int i = 0; i < got_pc.size(); i++) begin
            n_checks++;
            if ({got_pc[i], got_inst[i]} !== {BASE + 32'(4*i), (BASE + 32'(4*i)) ^ 32'h0F0F_0000})
                $display("FAIL wrap_order_%0d: got pc=%h inst=%h want pc=%h", i, got_pc[i], got_inst[i], BASE + 32'(4*i));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic rf;
            logic rs;
            logic fl;
            logic st;
            rf = !e_full() && $urandom_range(0, 2) != 0;
            rs = (m_pend.size() + m_drop) > 0 && $urandom_range(0, 2) != 0;
            fl = $urandom_range(0, 15) == 0;
            st = $urandom_range(0, 3) == 0;
            drive(rf, {$urandom_range(0, 32'hFFFF), 2'b00} | BASE, rs, $urandom, fl, st);
            if (obs_vec() !== exp_vec()) begin
                errs++;
                if (errs <= 5) $display("FAIL random_cyc_%0d: got %h want %h", cyc, obs_vec(), exp_vec());
            end
            tick();
        end
        n_checks++;
        if (errs != 0) $display("FAIL random_total: got %0d mismatches want 0", errs); else n_pass++;
    endtask

    initial begin
        bus.req_fire = 1'b0; bus.req_pc = '0; bus.imem_resp = 1'b0;
        bus.imem_rdata = '0; bus.flush = 1'b0; bus.stall = 1'b0;
        test_reset();
        test_basic();
        test_stall_full();
        test_flush_drop();
        test_flush_resp();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
